// File: rtl/hazard_stall_control_pkg.sv
// Shared definitions for the hazard/stall unit: PC-source encodings (also used by
// the forwarding unit and control decoder) and the RUN/STALL state encoding.
package hazard_stall_control_pkg;

  localparam logic [2:0] PCSRC_SEQ    = 3'b000;
  localparam logic [2:0] PCSRC_BRANCH = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_JR     = 3'b011;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  function automatic logic is_jr(input logic [2:0] pcsrc);
    return pcsrc == PCSRC_JR;
  endfunction

endpackage

// File: rtl/hazard_stall_control_if.sv
// Signal bundle between the pipeline (master) and the hazard/stall unit (slave).
// Optional HAZARD_STATS_EN adds the StallCycles/FlushCount statistics outputs.
interface hazard_stall_control_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 2
);
  import hazard_stall_control_pkg::*;

  logic             MemRead_ex;
  logic             RegWrite_ex;
  logic [REG_W-1:0] Write_register;
  logic             MemRead_mem;
  logic             RegWrite_mem;
  logic [REG_W-1:0] Write_register_mem;
  logic [REG_W-1:0] Rs;
  logic [REG_W-1:0] Rt;
  logic             UseRs;
  logic             UseRt;
  logic [2:0]       PCSrc;
  logic             BranchTaken_ex;

  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             StallBusy;

  // Debug view of the FSM state and the stall-remaining counter.
  state_t           dbg_state;
  logic [CNT_W-1:0] dbg_remaining;

`ifdef HAZARD_STATS_EN
  logic [31:0]      StallCycles;
  logic [31:0]      FlushCount;
`endif

  modport master (
    output MemRead_ex, RegWrite_ex, Write_register, MemRead_mem, RegWrite_mem,
           Write_register_mem, Rs, Rt, UseRs, UseRt, PCSrc, BranchTaken_ex,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, StallBusy,
           dbg_state, dbg_remaining
`ifdef HAZARD_STATS_EN
    , input StallCycles, FlushCount
`endif
  );

  modport slave (
    input  MemRead_ex, RegWrite_ex, Write_register, MemRead_mem, RegWrite_mem,
           Write_register_mem, Rs, Rt, UseRs, UseRt, PCSrc, BranchTaken_ex,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, StallBusy,
           dbg_state, dbg_remaining
`ifdef HAZARD_STATS_EN
    , output StallCycles, FlushCount
`endif
  );

endinterface

// File: rtl/hazard_stall_control_detect.sv
// Combinational hazard classifier: how many cycles the ID instruction must wait
// before the bypass network can serve it (0 = no stall needed).
module hazard_detect
  import hazard_stall_control_pkg::*;
#(
  parameter int REG_W         = 5,
  parameter int JR_LOAD_STALL = 2,
  parameter int CNT_W         = 2
) (
  input  logic             mem_read_ex,
  input  logic             reg_write_ex,
  input  logic [REG_W-1:0] wr_ex,
  input  logic             reg_write_mem,
  input  logic [REG_W-1:0] wr_mem,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic [2:0]       pcsrc,
  output logic [CNT_W-1:0] need
);

  logic jr_live;
  logic ex_match_rs;
  logic ex_match_rt;
  logic load_use;

  assign jr_live     = is_jr(pcsrc) && (rs != '0);
  assign ex_match_rs = use_rs && (wr_ex == rs);
  assign ex_match_rt = use_rt && (wr_ex == rt);
  assign load_use    = mem_read_ex && (wr_ex != '0) && (ex_match_rs || ex_match_rt);

  // jr resolves in ID, so it needs rs earlier than ordinary consumers do.
  always_comb begin
    need = '0;
    if (jr_live && mem_read_ex && reg_write_ex && (wr_ex == rs)) begin
      need = CNT_W'(JR_LOAD_STALL);
    end else if (jr_live && reg_write_mem && (wr_mem == rs)) begin
      need = CNT_W'(1);
    end else if (jr_live && reg_write_ex && !mem_read_ex && (wr_ex == rs)) begin
      need = '0;
    end else if (load_use) begin
      need = CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_control.sv
// Stall/flush controller: holds PC and IF/ID for counted stalls, bubbles ID/EX,
// and flushes on taken branches. Optional statistics via HAZARD_STATS_EN.
module hazard_stall_control
  import hazard_stall_control_pkg::*;
#(
  parameter int REG_W         = 5,
  parameter int JR_LOAD_STALL = 2,  // legal 1..3; 2**CNT_W must exceed it
  parameter int CNT_W         = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_stall_control_if.slave bus
);

  state_t           state, state_next;
  logic [CNT_W-1:0] remaining, rem_next;
  logic [CNT_W-1:0] need;
  logic             pc_write, ifid_write, ifid_flush, idex_flush;

  hazard_detect #(
    .REG_W         (REG_W),
    .JR_LOAD_STALL (JR_LOAD_STALL),
    .CNT_W         (CNT_W)
  ) u_detect (
    .mem_read_ex   (bus.MemRead_ex),
    .reg_write_ex  (bus.RegWrite_ex),
    .wr_ex         (bus.Write_register),
    .reg_write_mem (bus.RegWrite_mem),
    .wr_mem        (bus.Write_register_mem),
    .rs            (bus.Rs),
    .rt            (bus.Rt),
    .use_rs        (bus.UseRs),
    .use_rt        (bus.UseRt),
    .pcsrc         (bus.PCSrc),
    .need          (need)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= rem_next;
    end
  end

  // A taken branch overrides everything: the stalled instruction is wrong-path.
  always_comb begin
    state_next = state;
    rem_next   = remaining;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (bus.BranchTaken_ex) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_next = ST_RUN;
      rem_next   = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (need != '0) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (need > CNT_W'(1)) begin
              state_next = ST_STALL;
              rem_next   = need - CNT_W'(1);
            end
          end
        end
        ST_STALL: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          if (remaining <= CNT_W'(1)) begin
            state_next = ST_RUN;
            rem_next   = '0;
          end else begin
            rem_next = remaining - CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_RUN;
          rem_next   = '0;
        end
      endcase
    end
  end

  assign bus.PC_Write      = pc_write;
  assign bus.IF_ID_Write   = ifid_write;
  assign bus.IF_ID_Flush   = ifid_flush;
  assign bus.ID_EX_Flush   = idex_flush;
  assign bus.StallBusy     = (state == ST_STALL);
  assign bus.dbg_state     = state;
  assign bus.dbg_remaining = remaining;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write)          stall_cycles <= stall_cycles + 32'd1;
      if (bus.BranchTaken_ex) flush_count  <= flush_count + 32'd1;
    end
  end

  assign bus.StallCycles = stall_cycles;
  assign bus.FlushCount  = flush_count;
`endif

endmodule

// File: tb/tb_hazard_stall_control.sv
// Self-checking bench for hazard_stall_control: directed hazard cases, random
// traffic against a reference model, async reset mid-stall, optional stats.
module tb_hazard_stall_control;
  import hazard_stall_control_pkg::*;

  localparam int JR_STALL = 2;

  typedef struct packed {
    logic       memread_ex;
    logic       regwrite_ex;
    logic [4:0] wr_ex;
    logic       memread_mem;
    logic       regwrite_mem;
    logic [4:0] wr_mem;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [2:0] pcsrc;
    logic       branch;
  } in_t;

  logic clk;
  logic reset;
  hazard_stall_control_if #(.REG_W(5), .CNT_W(2)) bus ();

  hazard_stall_control #(.REG_W(5), .JR_LOAD_STALL(JR_STALL), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, StallBusy}

  int          model_left = 0;
  logic [31:0] exp_stall  = 0;
  logic [31:0] exp_flush  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_need(input in_t v);
    if (v.pcsrc == 3'b011 && v.rs != 0) begin
      if (v.memread_ex && v.regwrite_ex && v.wr_ex == v.rs) return JR_STALL;
      if (v.regwrite_mem && v.wr_mem == v.rs) return 1;
      if (v.regwrite_ex && v.wr_ex == v.rs) return 0;
    end
    if (v.memread_ex && v.wr_ex != 0 &&
        ((v.use_rs && v.wr_ex == v.rs) || (v.use_rt && v.wr_ex == v.rt))) return 1;
    return 0;
  endfunction

  task automatic apply(input in_t v);
    bus.MemRead_ex         = v.memread_ex;
    bus.RegWrite_ex        = v.regwrite_ex;
    bus.Write_register     = v.wr_ex;
    bus.MemRead_mem        = v.memread_mem;
    bus.RegWrite_mem       = v.regwrite_mem;
    bus.Write_register_mem = v.wr_mem;
    bus.Rs                 = v.rs;
    bus.Rt                 = v.rt;
    bus.UseRs              = v.use_rs;
    bus.UseRt              = v.use_rt;
    bus.PCSrc              = v.pcsrc;
    bus.BranchTaken_ex     = v.branch;
  endtask

  // driver: one cycle of stimulus plus its expected outputs
  task automatic drive(input in_t v);
    logic [4:0] e;
    int n;
    @(posedge clk);
    #1;
    apply(v);
    if (v.branch) begin
      e = {1'b1, 1'b1, 1'b1, 1'b1, (model_left > 0)};
      model_left = 0;
      exp_flush++;
    end else if (model_left > 0) begin
      e = 5'b00011;
      model_left--;
    end else begin
      n = ref_need(v);
      e = (n > 0) ? 5'b00010 : 5'b11000;
      model_left = (n > 0) ? n - 1 : 0;
    end
    if (!e[4]) exp_stall++;
    exp_q.push_back(e);
  endtask

  task automatic drive_idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive('0);
  endtask

  // scoreboard: compare on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      e = exp_q.pop_front();
      check("outputs", {27'd0, bus.PC_Write, bus.IF_ID_Write, bus.IF_ID_Flush,
                        bus.ID_EX_Flush, bus.StallBusy}, {27'd0, e});
    end
  end

  in_t v;

  initial begin
    apply('0);
    reset = 1'b1;
    #12;
    check("reset_outs", {27'd0, bus.PC_Write, bus.IF_ID_Write, bus.IF_ID_Flush,
                         bus.ID_EX_Flush, bus.StallBusy}, 32'b11000);
    check("reset_cnt", {30'd0, bus.dbg_remaining}, 32'd0);
    reset = 1'b0;
    drive_idle(2);

    // load-use on rs, then on rt
    v = '0; v.memread_ex = 1; v.regwrite_ex = 1; v.wr_ex = 8; v.rs = 8; v.use_rs = 1;
    drive(v); drive_idle(1);
    v = '0; v.memread_ex = 1; v.regwrite_ex = 1; v.wr_ex = 0; v.rs = 0; v.use_rs = 1;
    drive(v); drive_idle(1);
    v = '0; v.memread_ex = 1; v.regwrite_ex = 1; v.wr_ex = 5; v.rt = 5; v.use_rt = 1;
    drive(v); drive_idle(1);

    // jr after load: two stall cycles, inputs ignored during the second
    v = '0; v.pcsrc = PCSRC_JR; v.rs = 31; v.use_rs = 1;
    v.memread_ex = 1; v.regwrite_ex = 1; v.wr_ex = 31;
    drive(v); drive(v); drive_idle(2);

    // jr after ALU op in EX (forwarded), then in MEM (one stall)
    v = '0; v.pcsrc = PCSRC_JR; v.rs = 31; v.use_rs = 1; v.regwrite_ex = 1; v.wr_ex = 31;
    drive(v); drive_idle(1);
    v = '0; v.pcsrc = PCSRC_JR; v.rs = 31; v.use_rs = 1; v.regwrite_mem = 1; v.wr_mem = 31;
    drive(v); drive_idle(1);

    // taken branch during the second jr stall cycle cancels the stall
    v = '0; v.pcsrc = PCSRC_JR; v.rs = 31; v.use_rs = 1;
    v.memread_ex = 1; v.regwrite_ex = 1; v.wr_ex = 31;
    drive(v);
    v = '0; v.branch = 1;
    drive(v); drive_idle(2);

    // random traffic over a small register set to provoke matches
    for (int i = 0; i < 300; i++) begin
      v = '0;
      v.memread_ex   = 1'($urandom_range(0, 1));
      v.regwrite_ex  = 1'($urandom_range(0, 1));
      v.wr_ex        = 5'($urandom_range(0, 3));
      v.memread_mem  = 1'($urandom_range(0, 1));
      v.regwrite_mem = 1'($urandom_range(0, 1));
      v.wr_mem       = 5'($urandom_range(0, 3));
      v.rs           = 5'($urandom_range(0, 3));
      v.rt           = 5'($urandom_range(0, 3));
      v.use_rs       = 1'($urandom_range(0, 1));
      v.use_rt       = 1'($urandom_range(0, 1));
      v.pcsrc        = ($urandom_range(0, 2) == 0) ? PCSRC_JR : 3'($urandom_range(0, 7));
      v.branch       = ($urandom_range(0, 9) == 0);
      drive(v);
    end
    drive_idle(4);
    @(posedge clk);
    #1;
`ifdef HAZARD_STATS_EN
    check("stall_cycles", bus.StallCycles, exp_stall);
    check("flush_count", bus.FlushCount, exp_flush);
`endif

    // async reset while STALL with remaining==1
    v = '0; v.pcsrc = PCSRC_JR; v.rs = 31; v.use_rs = 1;
    v.memread_ex = 1; v.regwrite_ex = 1; v.wr_ex = 31;
    drive(v);
    @(posedge clk);
    #2;
    check("in_stall", {31'd0, bus.StallBusy}, 32'd1);
    check("stall_rem", {30'd0, bus.dbg_remaining}, 32'd1);
    apply('0);
    reset = 1'b1;
    model_left = 0; exp_stall = 0; exp_flush = 0;
    #1;
    check("rst_busy", {31'd0, bus.StallBusy}, 32'd0);
    check("rst_pcw", {31'd0, bus.PC_Write}, 32'd1);
    check("rst_cnt", {30'd0, bus.dbg_remaining}, 32'd0);
`ifdef HAZARD_STATS_EN
    check("rst_stats", bus.StallCycles | bus.FlushCount, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_idle(3);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_control.md
Name: hazard_stall_control

Overview:
- Pipeline hazard unit covering the cases the bypass network cannot: it stalls and flushes the pipeline instead of forwarding.
- Sits between the ID stage and the PC / IF-ID / ID-EX register enables.
- Detects load-use and jr-register hazards, holds the front end for a counted number of cycles, and flushes on taken branches.
- The stall counter is the sole authority while a stall is active; hazards are not re-evaluated mid-stall.

Parameters:
- REG_W, 5, register-number width
- JR_LOAD_STALL, 2, stall cycles when jr reads a register being loaded by the instruction in EX (legal range 1..3)
- CNT_W, 2, width of the stall-remaining counter; must satisfy 2^CNT_W > JR_LOAD_STALL

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- MemRead_ex  in  1  instruction in EX is a load
- RegWrite_ex  in  1  instruction in EX writes the register file
- Write_register  in  REG_W  destination register of the EX instruction
- MemRead_mem  in  1  instruction in MEM is a load
- RegWrite_mem  in  1  instruction in MEM writes the register file
- Write_register_mem  in  REG_W  destination register of the MEM instruction
- Rs  in  REG_W  rs of the instruction in ID
- Rt  in  REG_W  rt of the instruction in ID
- UseRs  in  1  ID instruction reads rs
- UseRt  in  1  ID instruction reads rt
- PCSrc  in  3  PC source of the ID instruction; 3'b011 = jr
- BranchTaken_ex  in  1  branch resolved taken in EX
- PC_Write  out  1  PC load enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  IF/ID register flush
- ID_EX_Flush  out  1  ID/EX register flush (inserts a bubble)
- StallBusy  out  1  counted stall in progress (state STALL)

Behaviour:
- Hazard need n (combinational, evaluated in RUN only), priority top-down:
  - jr case, when PCSrc==3'b011 and Rs!=0:
    - MemRead_ex && RegWrite_ex && Write_register==Rs -> n=JR_LOAD_STALL
    - RegWrite_mem && Write_register_mem==Rs (load or ALU) -> n=1
    - ALU result in EX matching Rs -> n=0 (handled by the jr forward path)
  - load-use: MemRead_ex && Write_register!=0 && ((UseRs && Write_register==Rs) || (UseRt && Write_register==Rt)) -> n=1
  - otherwise n=0.
- States and counter: RUN, STALL; 2-bit counter remaining.
- RUN, n==0: PC_Write=1, IF_ID_Write=1, both flushes 0.
- RUN, n>=1: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 in the same cycle. If n>=2, next state is STALL with remaining=n-1; otherwise stay in RUN.
- STALL: outputs as for a stall, StallBusy=1, no re-evaluation of hazards. remaining decrements each edge; when remaining==1 at an edge, next state is RUN.
- BranchTaken_ex has highest priority in either state:
  - IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, IF_ID_Write=1.
  - Next state RUN, remaining=0; any pending stall is cancelled, since the stalled instruction is wrong-path.
- Reset (asynchronous): state=RUN, remaining=0. Outputs during and after reset with idle inputs: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0, StallBusy=0.
- Reset asserted mid-stall: abandons the stall immediately, without waiting for the clock.
- Register 0 never causes a hazard.
- Latency: zero-cycle combinational response to hazard inputs in RUN; one-cycle registered transition into and out of STALL.

Optional Feature:
- Macro: HAZARD_STATS_EN
- Defined: adds outputs StallCycles[31:0] and FlushCount[31:0].
  - StallCycles increments every cycle PC_Write==0.
  - FlushCount increments every cycle BranchTaken_ex==1.
  - Both wrap at 2^32 and reset asynchronously to 0.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package holds the PCSrc encodings (PCSRC_JR=3'b011 and siblings) and the RUN/STALL state encoding.
- The PCSrc encodings are shared with the forwarding unit and the control decoder.
- One natural sub-module, hazard_detect: pure combinational computation of n. The parent holds the FSM, the counter and the optional stats counters.

Test Plan:
- Load-use: MemRead_ex=1, Write_register=8, Rs=8, UseRs=1 -> one cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Same setup with Rs=0 and Write_register=0 -> no stall.
- jr after load: PCSrc=3'b011, Rs=31, MemRead_ex=RegWrite_ex=1, Write_register=31 -> exactly 2 stall cycles, StallBusy=1 in the second cycle, then RUN.
- jr after ALU op: RegWrite_ex=1, MemRead_ex=0, Write_register=31 -> no stall. Same op in MEM instead (RegWrite_mem=1, Write_register_mem=31) -> 1 stall cycle.
- BranchTaken_ex=1 during the second jr stall cycle -> both flushes=1, PC_Write=1, state RUN the next cycle, no further stall.
- reset pulsed while in STALL with remaining=1 -> immediately StallBusy=0, PC_Write=1, counter 0.
- HAZARD_STATS_EN defined: three load-use stalls plus two taken branches -> StallCycles=3, FlushCount=2.
